// File: rtl/recv_partition_logic.sv
// ----------------------------------------------------------------------------
// recv_partition_logic
//
// Receive-side stage of the median-filter quickselect loop. For each frame it
// pops four control tokens (pivot, buffer size, median position, second median
// value) in one simultaneous pop, then pops buff_size pixels and partitions
// them against the pivot into a local buffer:
//   - pixels below the pivot fill upward from address 0
//   - pixels above the pivot fill downward from address buff_size-1
//   - pixels equal to the pivot are only counted
// The partition counts and latched tokens are then presented to the selection
// controller until it acknowledges them.
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   recv_px_*                        pixel FIFO (FWFT: data, empty, rd)
//   recv_pivot_*                     pivot token FIFO
//   recv_buff_size_*                 frame size token FIFO
//   recv_median_pos_*                median position token FIFO
//   recv_second_median_value_*       second median value token FIFO
//   buf_wr, buf_addr, buf_data       local buffer write port (combinational)
//   lt_count, eq_count, gt_count     partition counts (registered)
//   pivot, buff_size, median_pos,
//   second_median_value              latched tokens (registered)
//   result_valid, result_ack         result handshake
// ----------------------------------------------------------------------------
module recv_partition_logic #(
   parameter int BUFF_SIZE     = 32,
   parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
   parameter int DATA_WIDTH    = 8,
   parameter int BUFF_ADDR_BIT = $clog2(BUFF_SIZE)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    recv_px_data,
   input  logic                     recv_px_empty,
   output logic                     recv_px_rd,
   input  logic [DATA_WIDTH-1:0]    recv_pivot_data,
   input  logic                     recv_pivot_empty,
   output logic                     recv_pivot_rd,
   input  logic [BUFF_SIZE_BIT-1:0] recv_buff_size_data,
   input  logic                     recv_buff_size_empty,
   output logic                     recv_buff_size_rd,
   input  logic [BUFF_SIZE_BIT-1:0] recv_median_pos_data,
   input  logic                     recv_median_pos_empty,
   output logic                     recv_median_pos_rd,
   input  logic [DATA_WIDTH-1:0]    recv_second_median_value_data,
   input  logic                     recv_second_median_value_empty,
   output logic                     recv_second_median_value_rd,
   output logic                     buf_wr,
   output logic [BUFF_ADDR_BIT-1:0] buf_addr,
   output logic [DATA_WIDTH-1:0]    buf_data,
   output logic [BUFF_SIZE_BIT-1:0] lt_count,
   output logic [BUFF_SIZE_BIT-1:0] eq_count,
   output logic [BUFF_SIZE_BIT-1:0] gt_count,
   output logic [DATA_WIDTH-1:0]    pivot,
   output logic [BUFF_SIZE_BIT-1:0] buff_size,
   output logic [BUFF_SIZE_BIT-1:0] median_pos,
   output logic [DATA_WIDTH-1:0]    second_median_value,
   output logic                     result_valid,
   input  logic                     result_ack
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [BUFF_SIZE_BIT-1:0] SIZE_MAX = BUFF_SIZE_BIT'(BUFF_SIZE);
   localparam logic [BUFF_SIZE_BIT-1:0] ONE      = BUFF_SIZE_BIT'(1);

   state_t                   state_q, state_d;
   logic [BUFF_SIZE_BIT-1:0] lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
   logic [DATA_WIDTH-1:0]    pivot_q, pivot_d;
   logic [BUFF_SIZE_BIT-1:0] size_q, size_d;
   logic [BUFF_SIZE_BIT-1:0] med_q, med_d;
   logic [DATA_WIDTH-1:0]    sec_q, sec_d;
   logic                     valid_q, valid_d;

   logic                     ctrl_ready;
   logic                     ctrl_pop;
   logic                     px_pop;
   logic                     wr;
   logic [BUFF_ADDR_BIT-1:0] addr;
   logic [BUFF_SIZE_BIT-1:0] size_sat;
   logic [BUFF_SIZE_BIT-1:0] cnt_sum;
   logic                     px_lt, px_gt;

   // Control tokens are only taken as a complete set of four.
   assign ctrl_ready = ~(recv_pivot_empty | recv_buff_size_empty |
                         recv_median_pos_empty | recv_second_median_value_empty);

   // Oversized frames are clamped to the local buffer depth.
   assign size_sat = (recv_buff_size_data > SIZE_MAX) ? SIZE_MAX : recv_buff_size_data;

   assign cnt_sum = lt_q + eq_q + gt_q;
   assign px_lt   = (recv_px_data < pivot_q);
   assign px_gt   = (recv_px_data > pivot_q);

   always_comb begin
      state_d  = state_q;
      lt_d     = lt_q;
      eq_d     = eq_q;
      gt_d     = gt_q;
      pivot_d  = pivot_q;
      size_d   = size_q;
      med_d    = med_q;
      sec_d    = sec_q;
      valid_d  = valid_q;
      ctrl_pop = 1'b0;
      px_pop   = 1'b0;
      wr       = 1'b0;
      addr     = '0;

      case (state_q)
         ST_IDLE: begin
            if (ctrl_ready && !rst) begin
               ctrl_pop = 1'b1;
               pivot_d  = recv_pivot_data;
               size_d   = size_sat;
               med_d    = recv_median_pos_data;
               sec_d    = recv_second_median_value_data;
               lt_d     = '0;
               eq_d     = '0;
               gt_d     = '0;
               // An empty frame has nothing to receive; report immediately.
               if (size_sat == '0) begin
                  state_d = ST_DONE;
                  valid_d = 1'b1;
               end else begin
                  state_d = ST_RECV;
               end
            end
         end

         ST_RECV: begin
            if (!recv_px_empty && !rst) begin
               px_pop = 1'b1;
               if (px_lt) begin
                  wr   = 1'b1;
                  addr = lt_q[BUFF_ADDR_BIT-1:0];
                  lt_d = lt_q + ONE;
               end else if (px_gt) begin
                  wr   = 1'b1;
                  // Greater pixels grow down from the top of this frame's region.
                  addr = BUFF_ADDR_BIT'(size_q - ONE - gt_q);
                  gt_d = gt_q + ONE;
               end else begin
                  eq_d = eq_q + ONE;
               end
               // This pop completes the frame: stop popping and present results.
               if (cnt_sum + ONE == size_q) begin
                  state_d = ST_DONE;
                  valid_d = 1'b1;
               end
            end
         end

         ST_DONE: begin
            if (result_ack) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         lt_q    <= '0;
         eq_q    <= '0;
         gt_q    <= '0;
         pivot_q <= '0;
         size_q  <= '0;
         med_q   <= '0;
         sec_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
         pivot_q <= pivot_d;
         size_q  <= size_d;
         med_q   <= med_d;
         sec_q   <= sec_d;
         valid_q <= valid_d;
      end
   end

   assign recv_pivot_rd               = ctrl_pop;
   assign recv_buff_size_rd           = ctrl_pop;
   assign recv_median_pos_rd          = ctrl_pop;
   assign recv_second_median_value_rd = ctrl_pop;
   assign recv_px_rd                  = px_pop;

   assign buf_wr   = wr;
   assign buf_addr = addr;
   assign buf_data = recv_px_data;

   assign lt_count            = lt_q;
   assign eq_count            = eq_q;
   assign gt_count            = gt_q;
   assign pivot               = pivot_q;
   assign buff_size           = size_q;
   assign median_pos          = med_q;
   assign second_median_value = sec_q;
   assign result_valid        = valid_q;

endmodule

// File: tb/tb_recv_partition_logic.sv
// ----------------------------------------------------------------------------
// Testbench for recv_partition_logic. The bench owns five FWFT FIFO models
// (queues). Each frame pushed also pushes its expected buffer writes and its
// expected result into scoreboards; a negedge monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_recv_partition_logic;

   localparam int BS = 32;
   localparam int SB = 6;
   localparam int DW = 8;
   localparam int AB = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] recv_px_data;
   logic          recv_px_empty;
   logic          recv_px_rd;
   logic [DW-1:0] recv_pivot_data;
   logic          recv_pivot_empty;
   logic          recv_pivot_rd;
   logic [SB-1:0] recv_buff_size_data;
   logic          recv_buff_size_empty;
   logic          recv_buff_size_rd;
   logic [SB-1:0] recv_median_pos_data;
   logic          recv_median_pos_empty;
   logic          recv_median_pos_rd;
   logic [DW-1:0] recv_second_median_value_data;
   logic          recv_second_median_value_empty;
   logic          recv_second_median_value_rd;
   logic          buf_wr;
   logic [AB-1:0] buf_addr;
   logic [DW-1:0] buf_data;
   logic [SB-1:0] lt_count, eq_count, gt_count;
   logic [DW-1:0] pivot;
   logic [SB-1:0] buff_size, median_pos;
   logic [DW-1:0] second_median_value;
   logic          result_valid;
   logic          result_ack;

   always #5 clk = ~clk;

   recv_partition_logic #(.BUFF_SIZE(BS), .BUFF_SIZE_BIT(SB), .DATA_WIDTH(DW), .BUFF_ADDR_BIT(AB)) dut (
      .clk(clk), .rst(rst),
      .recv_px_data(recv_px_data), .recv_px_empty(recv_px_empty), .recv_px_rd(recv_px_rd),
      .recv_pivot_data(recv_pivot_data), .recv_pivot_empty(recv_pivot_empty), .recv_pivot_rd(recv_pivot_rd),
      .recv_buff_size_data(recv_buff_size_data), .recv_buff_size_empty(recv_buff_size_empty),
      .recv_buff_size_rd(recv_buff_size_rd),
      .recv_median_pos_data(recv_median_pos_data), .recv_median_pos_empty(recv_median_pos_empty),
      .recv_median_pos_rd(recv_median_pos_rd),
      .recv_second_median_value_data(recv_second_median_value_data),
      .recv_second_median_value_empty(recv_second_median_value_empty),
      .recv_second_median_value_rd(recv_second_median_value_rd),
      .buf_wr(buf_wr), .buf_addr(buf_addr), .buf_data(buf_data),
      .lt_count(lt_count), .eq_count(eq_count), .gt_count(gt_count),
      .pivot(pivot), .buff_size(buff_size), .median_pos(median_pos),
      .second_median_value(second_median_value),
      .result_valid(result_valid), .result_ack(result_ack)
   );

   typedef struct packed {
      logic [SB-1:0] lt;
      logic [SB-1:0] eq;
      logic [SB-1:0] gt;
      logic [DW-1:0] piv;
      logic [SB-1:0] sz;
      logic [SB-1:0] med;
      logic [DW-1:0] sec;
   } res_t;

   typedef struct packed {
      logic [15:0]   id;
      logic [AB-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   // FIFO contents
   logic [DW-1:0] q_px[$];
   logic [DW-1:0] q_piv[$];
   logic [SB-1:0] q_sz[$];
   logic [SB-1:0] q_med[$];
   logic [DW-1:0] q_sec[$];
   // Scoreboards
   wr_t           wq[$];
   res_t          rq[$];
   int            rid[$];
   // Pixels for the next pushed frame
   logic [DW-1:0] stage[$];

   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;
   int  last_pop = -10;
   int  fid   = 0;
   bit  prev_valid = 1'b0;
   bit  px_gate = 1'b0;
   bit  tog = 1'b0;
   bit  ctl_gate[4];
   bit  ctl_rand = 1'b0;
   int  bubble_mode = 0;

   task automatic drive_inputs();
      case (bubble_mode)
         1: begin tog = ~tog; px_gate = tog; end
         2: px_gate = ($urandom_range(0, 2) == 0);
         default: px_gate = 1'b0;
      endcase
      if (ctl_rand)
         for (int k = 0; k < 4; k++) ctl_gate[k] = ($urandom_range(0, 3) == 0);
      recv_px_empty    = px_gate || (q_px.size() == 0);
      recv_px_data     = recv_px_empty ? DW'($urandom) : q_px[0];
      recv_pivot_empty = ctl_gate[0] || (q_piv.size() == 0);
      recv_pivot_data  = recv_pivot_empty ? DW'($urandom) : q_piv[0];
      recv_buff_size_empty = ctl_gate[1] || (q_sz.size() == 0);
      recv_buff_size_data  = recv_buff_size_empty ? SB'($urandom) : q_sz[0];
      recv_median_pos_empty = ctl_gate[2] || (q_med.size() == 0);
      recv_median_pos_data  = recv_median_pos_empty ? SB'($urandom) : q_med[0];
      recv_second_median_value_empty = ctl_gate[3] || (q_sec.size() == 0);
      recv_second_median_value_data  = recv_second_median_value_empty ? DW'($urandom) : q_sec[0];
   endtask

   // Reference model: frame tokens plus staged pixels -> expected writes/result.
   task automatic push_frame(input logic [DW-1:0] piv, input logic [SB-1:0] sz_tok,
                             input logic [SB-1:0] med, input logic [DW-1:0] sec);
      int   eff;
      int   lt, eq, gt;
      wr_t  w;
      res_t r;
      eff = (int'(sz_tok) > BS) ? BS : int'(sz_tok);
      lt = 0; eq = 0; gt = 0;
      q_piv.push_back(piv);
      q_sz.push_back(sz_tok);
      q_med.push_back(med);
      q_sec.push_back(sec);
      foreach (stage[i]) begin
         q_px.push_back(stage[i]);
         w.id = 16'(fid);
         w.d  = stage[i];
         if (stage[i] < piv) begin
            w.a = AB'(lt); wq.push_back(w); lt++;
         end else if (stage[i] > piv) begin
            w.a = AB'(eff - 1 - gt); wq.push_back(w); gt++;
         end else begin
            eq++;
         end
      end
      r.lt = SB'(lt); r.eq = SB'(eq); r.gt = SB'(gt);
      r.piv = piv; r.sz = SB'(eff); r.med = med; r.sec = sec;
      rq.push_back(r);
      rid.push_back(fid);
      fid++;
      stage.delete();
   endtask

   function automatic logic [DW-1:0] rand_px(input logic [DW-1:0] piv);
      return ($urandom_range(0, 3) == 0) ? piv : DW'($urandom);
   endfunction

   task automatic flush();
      q_px.delete(); q_piv.delete(); q_sz.delete(); q_med.delete(); q_sec.delete();
      wq.delete(); rq.delete(); rid.delete(); stage.delete();
   endtask

   task automatic cycle(output bit cpop, output bit ppop);
      bit r_px, r_pv, r_sz, r_md, r_sc;
      logic [DW-1:0] d8;
      logic [SB-1:0] d6;
      @(negedge clk);
      r_px = recv_px_rd;
      r_pv = recv_pivot_rd;
      r_sz = recv_buff_size_rd;
      r_md = recv_median_pos_rd;
      r_sc = recv_second_median_value_rd;
      cpop = r_pv | r_sz | r_md | r_sc;
      ppop = r_px;
      @(posedge clk);
      if (r_px && q_px.size() > 0)  d8 = q_px.pop_front();
      if (r_pv && q_piv.size() > 0) d8 = q_piv.pop_front();
      if (r_sz && q_sz.size() > 0)  d6 = q_sz.pop_front();
      if (r_md && q_med.size() > 0) d6 = q_med.pop_front();
      if (r_sc && q_sec.size() > 0) d8 = q_sec.pop_front();
      #1;
      result_ack = result_valid && ($urandom_range(0, 2) == 0);
      drive_inputs();
   endtask

   task automatic run_until_idle(input int maxc);
      int n;
      bit c, p;
      n = 0;
      while (rq.size() != 0 && n < maxc) begin
         cycle(c, p);
         n++;
      end
      total++;
      if (rq.size() != 0) begin
         bad++;
         $display("FAIL timeout: pending_results=%0d required=0", rq.size());
         flush();
      end
   endtask

   // Monitor / scoreboard checker
   always @(negedge clk) begin
      bit   viol;
      wr_t  exp_w;
      res_t act;
      cyc++;
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         viol = (recv_px_rd && recv_px_empty) ||
                (recv_pivot_rd && recv_pivot_empty) ||
                (recv_buff_size_rd && recv_buff_size_empty) ||
                (recv_median_pos_rd && recv_median_pos_empty) ||
                (recv_second_median_value_rd && recv_second_median_value_empty) ||
                !((recv_pivot_rd == recv_buff_size_rd) && (recv_pivot_rd == recv_median_pos_rd) &&
                  (recv_pivot_rd == recv_second_median_value_rd)) ||
                (buf_wr && !recv_px_rd);
         total++;
         if (viol) begin
            bad++;
            $display("FAIL protocol: rd=%b%b%b%b%b empty=%b%b%b%b%b wr=%b required=no pop on empty, all-or-none control pop, wr only with pop",
                     recv_px_rd, recv_pivot_rd, recv_buff_size_rd, recv_median_pos_rd, recv_second_median_value_rd,
                     recv_px_empty, recv_pivot_empty, recv_buff_size_empty, recv_median_pos_empty,
                     recv_second_median_value_empty, buf_wr);
         end
         if (buf_wr) begin
            total++;
            if (wq.size() == 0) begin
               bad++;
               $display("FAIL buf_write: got addr=%0d data=%0d, required no write", buf_addr, buf_data);
            end else begin
               exp_w = wq.pop_front();
               if (buf_addr !== exp_w.a || buf_data !== exp_w.d) begin
                  bad++;
                  $display("FAIL buf_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                           buf_addr, buf_data, exp_w.a, exp_w.d);
               end
            end
         end
         if (result_valid) begin
            total++;
            act.lt = lt_count; act.eq = eq_count; act.gt = gt_count;
            act.piv = pivot; act.sz = buff_size; act.med = median_pos; act.sec = second_median_value;
            if (rq.size() == 0) begin
               bad++;
               $display("FAIL result: result_valid=1, required no pending result");
            end else begin
               if (act !== rq[0]) begin
                  bad++;
                  $display("FAIL result: got lt=%0d eq=%0d gt=%0d piv=%0d sz=%0d med=%0d sec=%0d, required lt=%0d eq=%0d gt=%0d piv=%0d sz=%0d med=%0d sec=%0d",
                           act.lt, act.eq, act.gt, act.piv, act.sz, act.med, act.sec,
                           rq[0].lt, rq[0].eq, rq[0].gt, rq[0].piv, rq[0].sz, rq[0].med, rq[0].sec);
               end
               if (!prev_valid) begin
                  total++;
                  if (cyc != last_pop + 1 || (wq.size() != 0 && int'(wq[0].id) == rid[0])) begin
                     bad++;
                     $display("FAIL valid_timing: valid at cycle %0d with %0d writes pending, required cycle %0d with all writes done",
                              cyc, wq.size(), last_pop + 1);
                  end
               end
               if (result_ack) begin
                  rq.pop_front();
                  rid.pop_front();
               end
            end
         end
         prev_valid = result_valid;
         if (recv_px_rd || recv_pivot_rd) last_pop = cyc;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit c, p;
      int pops, n;
      logic [DW-1:0] piv;
      logic [SB-1:0] sz;
      int eff;
      logic [DW-1:0] basic[5];

      basic[0] = 8'd50; basic[1] = 8'd100; basic[2] = 8'd150; basic[3] = 8'd20; basic[4] = 8'd100;
      for (int k = 0; k < 4; k++) ctl_gate[k] = 1'b0;
      rst = 1'b1;
      result_ack = 1'b0;

      // Reset held with every FIFO non-empty: nothing may pop.
      for (int i = 0; i < 5; i++) stage.push_back(basic[i]);
      push_frame(8'd100, 6'd5, 6'd2, 8'd77);
      drive_inputs();
      repeat (3) begin
         @(negedge clk);
         total++;
         if ({recv_px_rd, recv_pivot_rd, recv_buff_size_rd, recv_median_pos_rd,
              recv_second_median_value_rd, buf_wr, result_valid} !== 7'b0 ||
             lt_count !== 6'd0 || eq_count !== 6'd0 || gt_count !== 6'd0) begin
            bad++;
            $display("FAIL reset_outputs: rd/wr/valid=%b%b%b%b%b%b%b counts=%0d/%0d/%0d, required all 0",
                     recv_px_rd, recv_pivot_rd, recv_buff_size_rd, recv_median_pos_rd,
                     recv_second_median_value_rd, buf_wr, result_valid, lt_count, eq_count, gt_count);
         end
      end
      @(posedge clk);
      #1 rst = 1'b0;
      cycle(c, p);
      total++;
      if (!c) begin
         bad++;
         $display("FAIL first_pop: control pop=%0d, required 1", c);
      end
      // Basic partition (writes (0,50) (4,150) (1,20); lt=2 eq=2 gt=1)
      run_until_idle(200);

      // Same frame with a bubble on alternate cycles
      bubble_mode = 1;
      for (int i = 0; i < 5; i++) stage.push_back(basic[i]);
      push_frame(8'd100, 6'd5, 6'd3, 8'd9);
      drive_inputs();
      run_until_idle(200);
      bubble_mode = 0;

      // Pivot FIFO held empty for 4 cycles: no pops, then one 4-way pop
      ctl_gate[0] = 1'b1;
      for (int i = 0; i < 3; i++) stage.push_back(rand_px(8'd60));
      push_frame(8'd60, 6'd3, 6'd1, 8'd61);
      drive_inputs();
      repeat (4) begin
         cycle(c, p);
         total++;
         if (c) begin
            bad++;
            $display("FAIL stagger_hold: control pop=%0d, required 0", c);
         end
      end
      ctl_gate[0] = 1'b0;
      drive_inputs();
      cycle(c, p);
      total++;
      if (!c) begin
         bad++;
         $display("FAIL stagger_pop: control pop=%0d, required 1", c);
      end
      run_until_idle(200);

      // Size 0: result straight after the control pop
      push_frame(8'd33, 6'd0, 6'd0, 8'd44);
      drive_inputs();
      run_until_idle(50);

      // Size 32, all 255, pivot 0: addresses 31 down to 0
      for (int i = 0; i < 32; i++) stage.push_back(8'd255);
      push_frame(8'd0, 6'd32, 6'd16, 8'd5);
      drive_inputs();
      run_until_idle(300);

      // Size token 40 clamps to 32
      for (int i = 0; i < 32; i++) stage.push_back(rand_px(8'd128));
      push_frame(8'd128, 6'd40, 6'd20, 8'd200);
      drive_inputs();
      run_until_idle(300);

      // Reset after 3 pixel pops of a 5-pixel frame
      for (int i = 0; i < 5; i++) stage.push_back(basic[i]);
      push_frame(8'd100, 6'd5, 6'd2, 8'd1);
      drive_inputs();
      pops = 0; n = 0;
      while (pops < 3 && n < 100) begin
         cycle(c, p);
         if (p) pops++;
         n++;
      end
      result_ack = 1'b0;
      rst = 1'b1;
      #1;
      total++;
      if ({recv_px_rd, recv_pivot_rd, recv_buff_size_rd, recv_median_pos_rd,
           recv_second_median_value_rd, buf_wr, result_valid} !== 7'b0 ||
          lt_count !== 6'd0 || eq_count !== 6'd0 || gt_count !== 6'd0 || pivot !== 8'd0 ||
          buff_size !== 6'd0 || median_pos !== 6'd0 || second_median_value !== 8'd0) begin
         bad++;
         $display("FAIL midframe_reset: rd/wr/valid=%b%b%b%b%b%b%b counts=%0d/%0d/%0d piv=%0d sz=%0d, required all 0",
                  recv_px_rd, recv_pivot_rd, recv_buff_size_rd, recv_median_pos_rd,
                  recv_second_median_value_rd, buf_wr, result_valid, lt_count, eq_count, gt_count,
                  pivot, buff_size);
      end
      flush();
      drive_inputs();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 5; i++) stage.push_back(basic[i]);
      push_frame(8'd100, 6'd5, 6'd4, 8'd2);
      drive_inputs();
      run_until_idle(200);

      // Randomized frames, two queued at a time, random bubbles and token stalls
      ctl_rand = 1'b1;
      for (int f = 0; f < 30; f++) begin
         bubble_mode = $urandom_range(0, 2);
         for (int j = 0; j < 2; j++) begin
            piv = DW'($urandom);
            sz  = SB'($urandom_range(0, 36));
            eff = (int'(sz) > BS) ? BS : int'(sz);
            for (int i = 0; i < eff; i++) stage.push_back(rand_px(piv));
            push_frame(piv, sz, SB'($urandom_range(0, 31)), DW'($urandom));
         end
         drive_inputs();
         run_until_idle(600);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
